bpsk_symbol_modulator: RTL

- Downstream consumer of the transmitter's packet serializer.
- Paces the serializer by strobing `next` once per symbol and captures the returned `signal_stream` bit.
- Produces a phase-continuous, BPSK-modulated digital carrier. Each bit selects the carrier sign: 1 → +carrier, 0 → −carrier.
- Output feeds the DAC interface.

---
 rtl/bpsk_symbol_modulator_if.sv | 24 ++
 rtl/bpsk_symbol_modulator.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bpsk_symbol_modulator_if.sv
// Serializer/DAC-side bundle for the BPSK modulator: bit request/return plus sample stream.
// master = bit source / sample sink, slave = modulator.
interface bpsk_symbol_modulator_if #(
  parameter int SAMPLE_WIDTH = 8
);
  logic                           start;
  logic                           signal_stream;
  logic                           data_clear;
  logic                           next;
  logic signed [SAMPLE_WIDTH-1:0] sample_out;
  logic                           sample_valid;
  logic                           busy;
  logic                           tx_done;

  modport master (
    output start, signal_stream, data_clear,
    input  next, sample_out, sample_valid, busy, tx_done
  );

  modport slave (
    input  start, signal_stream, data_clear,
    output next, sample_out, sample_valid, busy, tx_done
  );
endinterface

// File: rtl/bpsk_symbol_modulator.sv
// BPSK carrier modulator: paces the serializer with `next`, one sample per CLKS_PER_SAMPLE clks.
// Sample appears one clk after its tick; the bit source must answer `next` on the following cycle.
module bpsk_symbol_modulator #(
  parameter int                     SAMPLE_WIDTH       = 8,
  parameter int                     PHASE_WIDTH        = 16,
  parameter int                     LUT_ADDR_WIDTH     = 6,
  parameter logic [PHASE_WIDTH-1:0] PHASE_INC          = 16'h2000,
  parameter int                     SAMPLES_PER_SYMBOL = 8,
  parameter int                     CLKS_PER_SAMPLE    = 4
) (
  input logic                clk,
  input logic                rst,
  bpsk_symbol_modulator_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam int PEAK  = 2**(SAMPLE_WIDTH-1) - 1;
  localparam int LUT_N = 2**LUT_ADDR_WIDTH;
  localparam int DIV_W = $clog2(CLKS_PER_SAMPLE);
  localparam int SYM_W = $clog2(SAMPLES_PER_SYMBOL);

  // Quarter-wave sine table built at elaboration with a Q30 fixed-point Taylor series.
  function automatic logic [LUT_N*SAMPLE_WIDTH-1:0] build_lut();
    logic [LUT_N*SAMPLE_WIDTH-1:0] t;
    longint x, x2, term, sum, v;
    t = '0;
    for (int i = 0; i < LUT_N; i++) begin
      x    = (64'sd3373259426 * i) >>> (LUT_ADDR_WIDTH + 1);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int k = 1; k <= 6; k++) begin
        term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
        sum  = sum + term;
      end
      v = (longint'(PEAK) * sum + (64'sd1 <<< 29)) >>> 30;
      t[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = SAMPLE_WIDTH'(v);
    end
    return t;
  endfunction

  localparam logic [LUT_N*SAMPLE_WIDTH-1:0] LUT = build_lut();

  logic [1:0]                     state;
  logic [PHASE_WIDTH-1:0]         phase;
  logic [DIV_W-1:0]               div;
  logic [SYM_W-1:0]               sym_cnt;
  logic                           cur_bit;
  logic                           last;
  logic                           cap;
  logic                           fin;
  logic signed [SAMPLE_WIDTH-1:0] sample_q;
  logic                           sample_vld_q;
  logic                           tx_done_q;

  logic                           tick;
  logic                           sym_end;
  logic [1:0]                     quad;
  logic [LUT_ADDR_WIDTH-1:0]      addr;
  logic [LUT_ADDR_WIDTH-1:0]      lut_idx;
  logic signed [SAMPLE_WIDTH-1:0] mag;
  logic signed [SAMPLE_WIDTH-1:0] carrier;
  logic signed [SAMPLE_WIDTH-1:0] mod_val;

  assign tick    = (state == S_RUN) && !fin && (div == DIV_W'(CLKS_PER_SAMPLE - 1));
  assign sym_end = tick && (sym_cnt == SYM_W'(SAMPLES_PER_SYMBOL - 1));
  assign quad    = phase[PHASE_WIDTH-1 -: 2];
  assign addr    = phase[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];

  always_comb begin
    // Odd quadrants read the table backwards: 2^L-1-a is simply ~a.
    lut_idx = quad[0] ? ~addr : addr;
    mag     = LUT[lut_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    carrier = quad[1] ? -mag : mag;
    mod_val = cur_bit ? carrier : -carrier;
  end

  assign bus.next         = !rst && (((state == S_IDLE) && bus.start) || (sym_end && !last));
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = sample_vld_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.tx_done      = tx_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      phase        <= '0;
      div          <= '0;
      sym_cnt      <= '0;
      cur_bit      <= 1'b0;
      last         <= 1'b0;
      cap          <= 1'b0;
      fin          <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      sample_vld_q <= 1'b0;
      tx_done_q    <= 1'b0;
      cap          <= 1'b0;
      case (state)
        S_IDLE: begin
          sample_q <= '0;
          if (bus.start) state <= S_LOAD;
        end
        S_LOAD: begin
          cur_bit <= bus.signal_stream;
          phase   <= '0;
          sym_cnt <= '0;
          last    <= 1'b0;
          div     <= '0;
          fin     <= 1'b0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (fin) begin
            // Final sample has been presented; drop to idle with a zeroed output.
            state     <= S_IDLE;
            tx_done_q <= 1'b1;
            sample_q  <= '0;
            fin       <= 1'b0;
          end else begin
            div <= tick ? '0 : div + 1'b1;
            if (cap) begin
              cur_bit <= bus.signal_stream;
              last    <= bus.data_clear;
            end
            if (tick) begin
              sample_q     <= mod_val;
              sample_vld_q <= 1'b1;
              phase        <= phase + PHASE_INC;
              sym_cnt      <= sym_end ? '0 : sym_cnt + 1'b1;
              if (sym_end && last)  fin <= 1'b1;
              if (sym_end && !last) cap <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
